vga_timing_gen: RTL and testbench

- Pixel-timing stage directly upstream of the combinational drawing controller.
- Generates the 640x480@60 VGA raster: horizontal/vertical counters, sync, blanking and pixel clock.
- Drives xPixel/yPixel into the drawing controller, registers its colour output, and aligns that colour with delayed sync/blank for the DAC.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants, counter widths and the rgb type.
// Shared by vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_CW = $clog2(VGA_H_TOTAL);
    localparam int VGA_V_CW = $clog2(VGA_V_TOTAL);

    // Width of one test-pattern colour bar, in pixels.
    localparam int VGA_BAR_W = 80;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical) with its decode.
// Ports: clk, rst, en, wrap_in -> count, active, sync_n (active low), wrap_out.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         wrap_in,
    output logic [W-1:0] count,
    output logic         active,
    output logic         sync_n,
    output logic         wrap_out
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
    localparam logic [W-1:0] A_END = W'(ACTIVE);
    localparam logic [W-1:0] S_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] S_END = W'(ACTIVE + FP + SYNC);

    logic step;

    // The counter steps only when both strobes agree.
    assign step     = en & wrap_in;
    assign wrap_out = step & (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

    assign active = (count < A_END);
    assign sync_n = !((count >= S_BEG) && (count < S_END));

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster, pixel coords out, colour/sync/blank to DAC.
// Ports: clk, rst, colR/G/B in; xPixel, yPixel, VGA_*, frameStart out.
// Option VGA_TIMING_TEST_PATTERN_EN adds testMode (8 vertical colour bars).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic       testMode,
`endif
    input  logic [7:0] colR,
    input  logic [7:0] colG,
    input  logic [7:0] colB,
    output logic [9:0] xPixel,
    output logic [8:0] yPixel,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_CLK,
    output logic       frameStart
);

    localparam int HW   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF = (CLK_DIV + 1) / 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic          pix_tick;
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          h_act;
    logic          v_act;
    logic          h_sn;
    logic          v_sn;
    logic          h_wrap;
    logic          v_wrap;
    logic          act;
    logic [9:0]    x_nxt;
    logic [8:0]    y_nxt;
    rgb_t          pix;

    assign pix_tick = (div == DIV_LAST);
    assign div_nxt  = pix_tick ? '0 : div + DW'(1);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (HW)
    ) u_h (
        .clk      (clk),
        .rst      (rst),
        .en       (pix_tick),
        .wrap_in  (1'b1),
        .count    (h_cnt),
        .active   (h_act),
        .sync_n   (h_sn),
        .wrap_out (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (VW)
    ) u_v (
        .clk      (clk),
        .rst      (rst),
        .en       (h_wrap),
        .wrap_in  (1'b1),
        .count    (v_cnt),
        .active   (v_act),
        .sync_n   (v_sn),
        .wrap_out (v_wrap)
    );

    // Values the counters take after this clk; the coordinate
    // registers load from these so they move with the counters.
    assign h_nxt = h_wrap   ? '0 :
                   pix_tick ? h_cnt + HW'(1) : h_cnt;
    assign v_nxt = v_wrap   ? '0 :
                   h_wrap   ? v_cnt + VW'(1) : v_cnt;

    assign x_nxt = (h_nxt < HW'(H_ACTIVE)) ? 10'(h_nxt) : '0;
    assign y_nxt = (v_nxt < VW'(V_ACTIVE)) ? 9'(v_nxt) : '0;

    assign act = h_act & v_act;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;

    // xPixel still holds the coordinate being registered this tick.
    assign bar = 3'(xPixel / 10'(VGA_BAR_W));

    always_comb begin
        pix = '{r: colR, g: colG, b: colB};
        if (testMode) begin
            pix = '{r: {8{bar[2]}}, g: {8{bar[1]}}, b: {8{bar[0]}}};
        end
    end
`else
    always_comb begin
        pix = '{r: colR, g: colG, b: colB};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            VGA_CLK     <= 1'b0;
            frameStart  <= 1'b0;
            xPixel      <= '0;
            yPixel      <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            div        <= div_nxt;
            VGA_CLK    <= (int'(div_nxt) < HALF);
            // v_wrap marks the tick that returns the raster to (0,0).
            frameStart <= v_wrap;
            if (pix_tick) begin
                xPixel      <= x_nxt;
                yPixel      <= y_nxt;
                VGA_HS      <= h_sn;
                VGA_VS      <= v_sn;
                VGA_BLANK_N <= act;
                {VGA_R, VGA_G, VGA_B} <= act ? pix : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized raster check against an arithmetic model.
// Uses a reduced timing set so several whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int D   = 3;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 4;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FR  = HT * VT;
    localparam int FRC = FR * D;
    localparam int SPX = 5;
    localparam int SPY = 3;

    localparam logic [47:0] RST_VEC =
        {10'd0, 9'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] colR;
    logic [7:0] colG;
    logic [7:0] colB;
    logic [9:0] xPixel;
    logic [8:0] yPixel;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_CLK;
    logic       frameStart;
    logic [47:0] got;

    int          mode = 0;
    logic [31:0] seed = 32'd0;
    int checks = 0;
    int failures = 0;
    int k = 0;

    int hs_prev, hs_run, hs_valid, last_hs_fall;
    int vs_prev, vs_run, vs_valid;
    int last_fs, ref_k, fs_pending, fs_cnt;
    int bn_cnt, a5_cnt, first_a5, viol;

    always #5 clk = ~clk;

    function automatic logic [23:0] stim_col(int m, logic [31:0] s,
                                             int x, int y);
        logic [31:0] v;
        if (m == 1) return (x == SPX && y == SPY) ? 24'hA50000 : 24'h0;
        if (m == 2) return 24'hFFFFFF;
        v = (32'(x) * 32'd40503 + 32'(y) * 32'd9973) ^ s;
        v = v ^ (v >> 13);
        v = v * 32'd2654435761;
        return v[23:0];
    endfunction

    assign {colR, colG, colB} =
        stim_col(mode, seed, int'(xPixel), int'(yPixel));

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic testMode;
    assign testMode = 1'b0;
`endif

    vga_timing_gen #(
        .CLK_DIV  (D),
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HSY),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .testMode    (testMode),
`endif
        .colR        (colR),
        .colG        (colG),
        .colB        (colB),
        .xPixel      (xPixel),
        .yPixel      (yPixel),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_CLK     (VGA_CLK),
        .frameStart  (frameStart)
    );

    assign got = {xPixel, yPixel, VGA_R, VGA_G, VGA_B,
                  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frameStart};

    // Output state kk clks after reset release, from raster arithmetic.
    function automatic logic [47:0] model(int kk, int m, logic [31:0] s);
        int t, p, h, v, q, hq, vq;
        logic act, hs, vs, ck, fs;
        logic [23:0] rgb;
        logic [9:0] x;
        logic [8:0] y;
        t  = kk / D;
        p  = t % FR;
        h  = p % HT;
        v  = p / HT;
        x  = (h < HA) ? 10'(h) : 10'd0;
        y  = (v < VA) ? 9'(v) : 9'd0;
        ck = (kk > 0) && ((kk % D) < (D + 1) / 2);
        fs = (kk > 0) && (kk % D == 0) && (p == 0);
        if (t == 0) begin
            act = 1'b0;
            hs  = 1'b1;
            vs  = 1'b1;
            rgb = 24'h0;
        end else begin
            q   = (t - 1) % FR;
            hq  = q % HT;
            vq  = q / HT;
            act = (hq < HA) && (vq < VA);
            hs  = !(hq >= HA + HFP && hq < HA + HFP + HSY);
            vs  = !(vq >= VA + VFP && vq < VA + VFP + VSY);
            rgb = act ? stim_col(m, s, hq, vq) : 24'h0;
        end
        return {x, y, rgb, hs, vs, act, ck, fs};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(string name);
        checks++;
        if (got !== RST_VEC) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, RST_VEC);
        end
    endtask

    task automatic clear_meas();
        hs_prev = 1; hs_run = 0; hs_valid = 0; last_hs_fall = -1;
        vs_prev = 1; vs_run = 0; vs_valid = 0;
        last_fs = -1; ref_k = 0; fs_pending = 1; fs_cnt = 0;
        bn_cnt = 0; a5_cnt = 0; first_a5 = -1; viol = 0;
    endtask

    task automatic sample();
        logic [47:0] want;
        want = model(k, mode, seed);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL cycle k=%0d mode=%0d: got %h, want %h",
                     k, mode, got, want);
        end
        if (VGA_BLANK_N) bn_cnt++;
        if (mode == 2 && !VGA_BLANK_N && {VGA_R, VGA_G, VGA_B} != 24'h0)
            viol++;
        if (mode == 1 && VGA_R == 8'hA5) begin
            a5_cnt++;
            if (first_a5 < 0) begin
                first_a5 = k;
                chk("spot_first_k", k, 243);
                chk("spot_blank_n", int'(VGA_BLANK_N), 1);
            end
        end
        if (frameStart) begin
            if (last_fs < 0) chk("first_frame_start", k, 1125);
            else chk("frame_period", k - last_fs, 1125);
            chk("visible_samples", bn_cnt, 384);
            if (mode == 1) chk("spot_count", a5_cnt, 3);
            if (mode == 2) chk("blank_forced_zero", viol, 0);
            bn_cnt = 0; a5_cnt = 0; viol = 0;
            last_fs = k; ref_k = k; fs_pending = 1; fs_cnt++;
        end
        if (hs_prev == 1 && !VGA_HS) begin
            if (last_hs_fall >= 0) chk("hs_period", k - last_hs_fall, 75);
            if (fs_pending == 1) begin
                chk("hs_fall_after_x0", k - ref_k, 57);
                fs_pending = 0;
            end
            last_hs_fall = k; hs_run = 0; hs_valid = 1;
        end
        if (!VGA_HS) hs_run++;
        if (hs_prev == 0 && VGA_HS && hs_valid == 1)
            chk("hs_width", hs_run, 9);
        hs_prev = int'(VGA_HS);
        if (vs_prev == 1 && !VGA_VS) begin
            vs_run = 0; vs_valid = 1;
        end
        if (!VGA_VS) vs_run++;
        if (vs_prev == 0 && VGA_VS && vs_valid == 1)
            chk("vs_width", vs_run, 150);
        vs_prev = int'(VGA_VS);
    endtask

    task automatic do_reset(int m);
        @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        mode = m;
        seed = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_held");
        rst = 1'b0;
        k = 0;
        clear_meas();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            sample();
        end
    endtask

    initial begin
        clear_meas();
        for (int e = 0; e < 6; e++) begin
            do_reset(e % 3);
            run(2 * FRC + 200 + int'($urandom_range(0, FRC)));
            chk("frames_in_epoch", fs_cnt, k / FRC);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
